// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word,
// instruction field widths and the branch-offset sign-extension helper.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } ifuState_t;

  localparam int INSTR_WIDTH  = 32;
  localparam int OFFSET_WIDTH = 16;
  localparam int JUMP_WIDTH   = 26;

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

  // Wide enough for any sane PC_WIDTH; callers truncate to their own width.
  function automatic logic [63:0] signExtend16(input logic [OFFSET_WIDTH-1:0] value);
    return {{48{value[OFFSET_WIDTH-1]}}, value};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls from decode-execute, the instruction
// memory read port, and the IR outputs toward decode.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);

  logic                    Stall;
  logic                    BranchTaken;
  logic [OFFSET_WIDTH-1:0] BranchOffset;
  logic                    Jump;
  logic [JUMP_WIDTH-1:0]   JumpTarget;
  logic [INSTR_WIDTH-1:0]  Instruction;
  logic [PC_WIDTH-1:0]     ReadAddress;
  logic [INSTR_WIDTH-1:0]  Ir;
  logic [PC_WIDTH-1:0]     IrPc;
  logic                    IrValid;
  logic [CNT_WIDTH-1:0]    FetchCount;

  modport master (
    input  Stall, BranchTaken, BranchOffset, Jump, JumpTarget, Instruction,
    output ReadAddress, Ir, IrPc, IrValid, FetchCount
  );

  modport slave (
    output Stall, BranchTaken, BranchOffset, Jump, JumpTarget, Instruction,
    input  ReadAddress, Ir, IrPc, IrValid, FetchCount
  );

endinterface

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Combinational next-PC generation: sequential successor of the PC and the
// redirect target (jump has priority over branch), all wrapped to MEM_DEPTH.
module instruction_fetch_unit_next_pc_calc
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [PC_WIDTH-1:0]     irPc,
  input  logic [OFFSET_WIDTH-1:0] branchOffset,
  input  logic [JUMP_WIDTH-1:0]   jumpTarget,
  input  logic                    jump,
  output logic [PC_WIDTH-1:0]     seqPc,
  output logic [PC_WIDTH-1:0]     redirectPc
);

  localparam logic [PC_WIDTH-1:0] ADDR_MASK = PC_WIDTH'(MEM_DEPTH - 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1'b1);

  logic [PC_WIDTH-1:0] branchPc;
  logic [PC_WIDTH-1:0] jumpPc;

  // Targets are masked so the PC never leaves the instruction memory.
  always_comb begin
    seqPc    = (pc + PC_ONE) & ADDR_MASK;
    branchPc = (irPc + PC_ONE + PC_WIDTH'(signExtend16(branchOffset))) & ADDR_MASK;
    jumpPc   = {irPc[PC_WIDTH-1:JUMP_WIDTH], jumpTarget} & ADDR_MASK;
    if (jump) begin
      redirectPc = jumpPc;
    end else begin
      redirectPc = branchPc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: word PC, instruction register, stall/branch/jump redirects.
// Build option IFU_DELAY_SLOT_EN: MIPS delay slot instead of squashing on redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int RESET_PC  = 0,
  parameter int MEM_DEPTH = 256,
  parameter int CNT_WIDTH = 16
) (
  input logic                     Clk,
  input logic                     Reset_n,
  instruction_fetch_unit_if.master bus
);

  localparam logic [PC_WIDTH-1:0]  RESET_PC_W = PC_WIDTH'(RESET_PC);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1'b1);

  ifuState_t              stateReg, stateNext;
  logic [PC_WIDTH-1:0]    pcReg, pcNext;
  logic [INSTR_WIDTH-1:0] irReg, irNext;
  logic [PC_WIDTH-1:0]    irPcReg, irPcNext;
  logic                   irValidReg, irValidNext;
  logic [CNT_WIDTH-1:0]   fetchCountReg, fetchCountNext;

  logic [PC_WIDTH-1:0]    seqPc;
  logic [PC_WIDTH-1:0]    redirectPc;
  logic                   takeRedirect;
  logic                   takeStall;
  logic                   latchNow;

  instruction_fetch_unit_next_pc_calc #(
    .PC_WIDTH  (PC_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_nextPcCalc (
    .pc           (pcReg),
    .irPc         (irPcReg),
    .branchOffset (bus.BranchOffset),
    .jumpTarget   (bus.JumpTarget),
    .jump         (bus.Jump),
    .seqPc        (seqPc),
    .redirectPc   (redirectPc)
  );

  // A bubble carries no branch, so controls only act on a valid IR.
  assign takeRedirect = irValidReg & (bus.Jump | bus.BranchTaken);
  assign takeStall    = irValidReg & bus.Stall;

  // Next-state and next-register decode; redirect beats stall beats sequential.
  always_comb begin
    stateNext      = stateReg;
    pcNext         = pcReg;
    irNext         = irReg;
    irPcNext       = irPcReg;
    irValidNext    = irValidReg;
    fetchCountNext = fetchCountReg;
    latchNow       = 1'b0;

    case (stateReg)
      ST_RUN, ST_HOLD, ST_SQUASH: begin
        if (takeRedirect) begin
          pcNext = redirectPc;
`ifdef IFU_DELAY_SLOT_EN
          latchNow  = 1'b1;
          stateNext = ST_RUN;
`else
          irNext      = NOP_WORD;
          irValidNext = 1'b0;
          stateNext   = ST_SQUASH;
`endif
        end else if (takeStall) begin
          stateNext = ST_HOLD;
        end else begin
          pcNext    = seqPc;
          latchNow  = 1'b1;
          stateNext = ST_RUN;
        end
      end
      default: begin
        stateNext = ST_RUN;
      end
    endcase

    if (latchNow) begin
      irNext         = bus.Instruction;
      irPcNext       = pcReg;
      irValidNext    = 1'b1;
      fetchCountNext = fetchCountReg + CNT_ONE;
    end else begin
      fetchCountNext = fetchCountNext;
    end
  end

  // State and pipeline registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateReg      <= ST_RUN;
      pcReg         <= RESET_PC_W;
      irReg         <= NOP_WORD;
      irPcReg       <= {PC_WIDTH{1'b0}};
      irValidReg    <= 1'b0;
      fetchCountReg <= {CNT_WIDTH{1'b0}};
    end else begin
      stateReg      <= stateNext;
      pcReg         <= pcNext;
      irReg         <= irNext;
      irPcReg       <= irPcNext;
      irValidReg    <= irValidNext;
      fetchCountReg <= fetchCountNext;
    end
  end

  assign bus.ReadAddress = pcReg;
  assign bus.Ir          = irReg;
  assign bus.IrPc        = irPcReg;
  assign bus.IrValid     = irValidReg;
  assign bus.FetchCount  = fetchCountReg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random redirects,
// checked through a scoreboard fed by a queue-free reference fetch model.
module tb_instruction_fetch_unit;

  localparam int PCW   = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 256;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  instruction_fetch_unit_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus ();

  instruction_fetch_unit #(
    .PC_WIDTH  (PCW),
    .RESET_PC  (0),
    .MEM_DEPTH (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [DEPTH];
  assign bus.Instruction = mem[bus.ReadAddress[7:0]];

  typedef struct packed {
    logic [31:0] ra;
    logic [31:0] ir;
    logic [31:0] irPc;
    logic        irValid;
    logic [15:0] cnt;
  } obs_t;

  obs_t sb[$];
  int nChecks = 0;
  int nFails  = 0;

  // Reference model: architectural fetch state only
  int          mPc, mIrPc, mCnt;
  logic [31:0] mIr;
  logic        mValid;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void modelReset();
    mPc = 0; mIrPc = 0; mCnt = 0; mIr = 32'h0; mValid = 1'b0;
  endfunction

  function automatic void modelFetch();
    mIr = mem[mPc]; mIrPc = mPc; mValid = 1'b1; mCnt = (mCnt + 1) % 65536;
  endfunction

  function automatic void modelStep(input logic s, input logic b, input logic [15:0] o,
                                    input logic j, input logic [25:0] t);
    int target;
    if (mValid && (j || b)) begin
      if (j) target = int'(t) % DEPTH;
      else   target = ((mIrPc + 1 + int'($signed(o))) % DEPTH + DEPTH) % DEPTH;
`ifdef IFU_DELAY_SLOT_EN
      modelFetch();
`else
      mIr = 32'h0; mValid = 1'b0;
`endif
      mPc = target;
    end else if (mValid && s) begin
      mPc = mPc;
    end else begin
      modelFetch();
      mPc = (mPc + 1) % DEPTH;
    end
  endfunction

  function automatic obs_t expected();
    obs_t e;
    e.ra = 32'(mPc); e.ir = mIr; e.irPc = 32'(mIrPc); e.irValid = mValid; e.cnt = 16'(mCnt);
    return e;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic s, input logic b, input logic [15:0] o,
                       input logic j, input logic [25:0] t);
    bus.Stall = s; bus.BranchTaken = b; bus.BranchOffset = o; bus.Jump = j; bus.JumpTarget = t;
    modelStep(s, b, o, j, t);
    sb.push_back(expected());
    @(negedge Clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
  endtask

  task automatic doReset(input string tag);
    Reset_n = 1'b0;
    #1;
    check({tag, " rst ra"}, bus.ReadAddress, 0);
    check({tag, " rst ir"}, bus.Ir, 0);
    check({tag, " rst irpc"}, bus.IrPc, 0);
    check({tag, " rst valid"}, bus.IrValid, 0);
    check({tag, " rst cnt"}, bus.FetchCount, 0);
    modelReset();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Scoreboard monitor: one expectation per clock edge after reset
  initial begin
    obs_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb ra", bus.ReadAddress, e.ra);
        check("sb ir", bus.Ir, e.ir);
        check("sb irpc", bus.IrPc, e.irPc);
        check("sb valid", bus.IrValid, e.irValid);
        check("sb cnt", bus.FetchCount, e.cnt);
      end
    end
  end

  initial begin
    logic s, b, j;
    logic [15:0] o;
    logic [25:0] t;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = {8'(i), 24'($urandom)} | 32'h0000_0001;
    end
    mem[2] = 32'h1000_0001;
    bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchOffset = 16'h0;
    bus.Jump = 1'b0; bus.JumpTarget = 26'h0;
    modelReset();

    // Reset state, then sequential fetch
    @(negedge Clk);
    doReset("t1");
    check("t1 ra0", bus.ReadAddress, 0);
    idle();
    check("t1 ra1", bus.ReadAddress, 1);
    check("t1 ir", bus.Ir, mem[0]);
    check("t1 irpc", bus.IrPc, 0);
    check("t1 valid", bus.IrValid, 1);
    idle();
    check("t1 ra2", bus.ReadAddress, 2);

    // Stall freezes everything
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    check("t2 ra", bus.ReadAddress, 2);
    check("t2 ir", bus.Ir, mem[1]);
    check("t2 irpc", bus.IrPc, 1);
    check("t2 cnt", bus.FetchCount, 2);

    // Taken branch, offset +1 from IrPc=2
    idle();
    check("t3 irpc", bus.IrPc, 2);
    cycle(1'b0, 1'b1, 16'h0001, 1'b0, 26'h0);
    check("t3 ra", bus.ReadAddress, 4);
`ifdef IFU_DELAY_SLOT_EN
    check("t3 ds ir", bus.Ir, mem[3]);
    check("t3 ds valid", bus.IrValid, 1);
`else
    check("t3 bubble ir", bus.Ir, 0);
    check("t3 bubble valid", bus.IrValid, 0);
`endif
    idle();
    check("t3 ir4", bus.Ir, mem[4]);
    check("t3 irpc4", bus.IrPc, 4);

    // Jump beats branch on the same edge
    cycle(1'b0, 1'b1, 16'h0010, 1'b1, 26'd5);
    check("t4 jump prio", bus.ReadAddress, 5);

    // Asynchronous reset in the squash bubble
    doReset("t6");
    idle();
    check("t6 restart ra", bus.ReadAddress, 1);
    check("t6 restart ir", bus.Ir, mem[0]);

    // PC wrap and negative branch wrap
    for (int n = 0; n < 400 && mPc != 255; n++) idle();
    check("t5 pc255", bus.ReadAddress, 255);
    idle();
    check("t5 wrap", bus.ReadAddress, 0);
    for (int n = 0; n < 10 && !(mValid && mIrPc == 1); n++) idle();
    check("t5 irpc1", bus.IrPc, 1);
    cycle(1'b0, 1'b1, 16'hFFFD, 1'b0, 26'h0);
    check("t5 neg branch", bus.ReadAddress, 255);

    // Random stalls, branches, jumps and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset("rnd");
      end else begin
        s = ($urandom_range(0, 99) < 20);
        b = ($urandom_range(0, 99) < 15);
        j = ($urandom_range(0, 99) < 8);
        if ($urandom_range(0, 1) == 1) o = 16'($urandom);
        else o = 16'(int'($urandom_range(0, 20)) - 10);
        t = 26'($urandom);
        cycle(s, b, o, j, t);
      end
    end

    repeat (2) @(negedge Clk);
    check("sb drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
